// File: rtl/dvr_rr_arbiter.sv
// rtl/dvr_rr_arbiter.sv - round-robin burst arbiter sharing one registered valid/ready output channel
module dvr_rr_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_SRC    = 4,
    parameter int MAX_BURST  = 8,
    localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_SRC-1:0]            s_valid,
    output logic [NUM_SRC-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [SRC_W-1:0]              m_src,
    output logic                          busy
);

    localparam int CNT_W   = $clog2(MAX_BURST + 1);
    localparam int PAD_SRC = 2 ** SRC_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [SRC_W-1:0]      g_q, g_d;
    logic [SRC_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [SRC_W-1:0]      m_src_q, m_src_d;

    logic [PAD_SRC-1:0]    valid_pad;
    logic                  any_req;
    logic [SRC_W-1:0]      pick;
    logic                  out_free;
    logic                  g_valid;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  accept;
    logic                  burst_done;
    logic                  release_w;
    logic [SRC_W-1:0]      g_next;

    // Padding lets the grant index address the valid vector for any NUM_SRC.
    assign valid_pad = PAD_SRC'(s_valid);

    // Scan from ptr upward with explicit wrap; the lowest offset found last wins.
    always_comb begin
        logic [SRC_W:0]   sum;
        logic [SRC_W-1:0] cand;
        any_req = 1'b0;
        pick    = '0;
        sum     = '0;
        cand    = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + (SRC_W + 1)'(k);
            if (sum >= (SRC_W + 1)'(NUM_SRC)) begin
                sum = sum - (SRC_W + 1)'(NUM_SRC);
            end
            cand = sum[SRC_W-1:0];
            if (valid_pad[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    always_comb begin
        g_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (g_q == SRC_W'(i)) begin
                g_data = s_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign out_free   = !m_valid_q || m_ready;
    assign g_valid    = valid_pad[g_q];
    assign accept     = (state_q == ST_GRANT) && g_valid && out_free;
    assign burst_done = accept && (cnt_q == CNT_W'(MAX_BURST - 1));
    assign release_w  = (state_q == ST_GRANT) && (burst_done || !g_valid);
    assign g_next     = (g_q == SRC_W'(NUM_SRC - 1)) ? '0 : g_q + 1'b1;

    // Ready is masked during reset so no beat is taken that reset would discard.
    always_comb begin
        s_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s_ready[i] = !rst && (state_q == ST_GRANT) && (g_q == SRC_W'(i)) && out_free;
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_src_d   = m_src_q;

        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = g_data;
            m_src_d   = g_q;
            cnt_d     = cnt_q + 1'b1;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_GRANT;
                    g_d     = pick;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (release_w) begin
                    state_d = ST_IDLE;
                    ptr_d   = g_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            g_q       <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_src_q   <= '0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_src_q   <= m_src_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_src   = m_src_q;
    assign busy    = (state_q == ST_GRANT);

endmodule

// File: doc/dvr_rr_arbiter.md
# dvr_rr_arbiter

Round-robin arbiter that shares one downstream data/valid/ready channel among NUM_SRC upstream data/valid/ready sources. It grants one source at a time and holds the grant for a burst of up to MAX_BURST beats, or until the source drops valid. Granted beats pass through a single registered output stage that carries the source index alongside the data. It sits in front of any shared sink: DMA engine, shared FIFO or host link.

## Interface
- DATA_WIDTH, 128, width of one data beat
- NUM_SRC, 4, number of upstream sources (>= 1)
- MAX_BURST, 8, maximum accepted beats per grant (>= 1)

- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_data  input  NUM_SRC*DATA_WIDTH  source data, source i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_valid  input  NUM_SRC  per-source valid
- s_ready  output  NUM_SRC  per-source ready
- m_data  output  DATA_WIDTH  registered output data
- m_valid  output  1  registered output valid
- m_ready  input  1  downstream ready
- m_src  output  SRC_W  index of the source that produced m_data; SRC_W = max(1, $clog2(NUM_SRC))
- busy  output  1  high while in GRANT state

## Operation
- **State machine:** IDLE, GRANT.
- **Registers:**
  - grant index g (SRC_W)
  - round-robin pointer ptr (SRC_W)
  - burst counter cnt ($clog2(MAX_BURST+1) bits)
  - output register {m_valid, m_data, m_src}
- **IDLE:**
  - If any s_valid is high, select the first i with s_valid[i]=1, searching ptr, ptr+1, …, wrapping modulo NUM_SRC.
  - Load g=i, clear cnt, and go to GRANT.
  - If no s_valid is high, stay in IDLE.
  - All s_ready are 0.
- **GRANT:**
  - out_free = !m_valid || m_ready.
  - s_ready[g] = out_free; every other s_ready = 0.
  - Accept = s_valid[g] && s_ready[g]. On accept: m_data <= s_data[g], m_src <= g, m_valid <= 1, cnt <= cnt+1.
- **Release:** leave GRANT for IDLE at the clock edge where either condition holds:
  - accept occurs with cnt == MAX_BURST-1 (burst complete), or
  - s_valid[g] == 0 (source stalled or finished; no beat accepted that cycle).
- On release, ptr <= (g+1) mod NUM_SRC. The wrap must be explicit for non-power-of-2 NUM_SRC.
- **Output register:** m_valid clears when m_ready is high and no new beat is accepted that cycle. While m_valid=1 and m_ready=0, m_data and m_src hold stable.
- The block never drops or duplicates a beat outside reset.

## Timing
- **Reset values** (any cycle rst=1, including mid-burst):
  - state=IDLE, ptr=0, g=0, cnt=0
  - m_valid=0, m_data=0, m_src=0
  - s_ready=0, busy=0
  - Any beat held in the output register is discarded.
- **Grant latency:** s_valid[i] rises in IDLE cycle t → GRANT in t+1 with s_ready[i]=1 (if out_free) → first beat accepted at the end of t+1 → m_valid=1 in t+2.
- **Throughput:** 1 beat/clock within a burst when m_ready is held high.
- **Burst gap:** exactly one IDLE cycle between consecutive grants. A source released after MAX_BURST beats cannot regain the grant while any other source is requesting.
- **Simultaneous requests:** resolved purely by ptr order; after reset, source 0 wins.
- **Backpressure:** m_ready=0 with m_valid=1 forces s_ready[g]=0. The grant and cnt are held; the burst does not count stalls.
- **NUM_SRC=1:** ptr stays 0. **MAX_BURST=1:** release after every accepted beat.

## Test plan
- **Reset:** assert rst with sources valid; rst held 3 cycles → m_valid=0, s_ready=0000, busy=0 throughout.
- **Single source:** s_valid=0001, data 0x10..0x1F (16 beats), m_ready=1, MAX_BURST=8 → m_data 0x10..0x17 on consecutive cycles with m_src=0. Then one cycle with m_valid=0 (IDLE bubble), then 0x18..0x1F.
- **All sources, continuous:** s_valid=1111, m_ready=1 → bursts of 8 beats in order src 0,1,2,3,0 with a one-cycle gap between bursts. Per-source data order is preserved.
- **Early release:** src 2 drives 3 beats then drops valid while src 1 is valid → 3 beats with m_src=2, then release. ptr=3, so src 1 waits for the next scan and is granted unless src 3 is valid.
- **Backpressure:** m_ready toggles 1,0,0,1 during a burst → m_data stable during the low cycles. s_ready[g]=0 while m_valid=1 and m_ready=0. Exactly MAX_BURST beats are delivered per grant with no loss or duplication (scoreboard check).
- **Reset mid-burst:** rst=1 for 1 cycle after 4 beats of src 1 → next cycle m_valid=0. After reset, grant restarts from ptr=0 (src 0 first if valid).
